// File: rtl/spi_slave_port.sv
// SPI mode-0 slave port bridged into the HCLK domain, with a TX holding register and RX storage.
// Define SPI_SLAVE_RX_FIFO_EN for a 4-entry RX FIFO; otherwise RX storage is a single holding register.
module spi_slave_port #(
  parameter int DATA_W = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              SCLK,
  input  logic              SSn,
  input  logic              MOSI,
  output logic              MISO,
  output logic              MISO_oeb,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              busy,
  output logic              ovr,
  output logic              udr,
  input  logic              clr
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_ssn_s1, r_ssn_s2, r_ssn_d;
  logic r_mosi_s1, r_mosi_s2;
  logic [1:0] r_sync_vld;
  logic r_armed;

  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_rx_shift;
  logic [DATA_W-1:0] r_tx_shift;
  logic              r_tx_fresh;
  logic [DATA_W-1:0] r_tx_hold;
  logic              r_tx_full;
  logic              r_ovr, r_udr;

  logic              w_active, w_ssn_fall, w_sclk_rise, w_sclk_fall;
  logic              w_last_bit, w_byte_done;
  logic [DATA_W-1:0] w_rx_byte, w_tx_next;
  logic              w_tx_load, w_tx_push, w_udr_set;
  logic              w_rx_pop, w_rx_room, w_rx_wr, w_ovr_set;

  // Synchronizers; r_sync_vld marks when r_ssn_s2 reflects the pin rather than its reset value
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_sclk_s1  <= 1'b0;
      r_sclk_s2  <= 1'b0;
      r_sclk_d   <= 1'b0;
      r_ssn_s1   <= 1'b1;
      r_ssn_s2   <= 1'b1;
      r_ssn_d    <= 1'b1;
      r_mosi_s1  <= 1'b0;
      r_mosi_s2  <= 1'b0;
      r_sync_vld <= 2'b00;
      r_armed    <= 1'b0;
    end else begin
      r_sclk_s1  <= SCLK;
      r_sclk_s2  <= r_sclk_s1;
      r_sclk_d   <= r_sclk_s2;
      r_ssn_s1   <= SSn;
      r_ssn_s2   <= r_ssn_s1;
      r_ssn_d    <= r_ssn_s2;
      r_mosi_s1  <= MOSI;
      r_mosi_s2  <= r_mosi_s1;
      r_sync_vld <= {r_sync_vld[0], 1'b1};
      // A select still held low across reset must be released before a new frame is accepted
      if (r_sync_vld[1] && r_ssn_s2)
        r_armed <= 1'b1;
    end
  end

  assign w_active    = r_armed & ~r_ssn_s2;
  assign w_ssn_fall  = r_armed & r_ssn_d & ~r_ssn_s2;
  assign w_sclk_rise = w_active & ~w_ssn_fall & r_sclk_s2 & ~r_sclk_d;
  assign w_sclk_fall = w_active & ~w_ssn_fall & ~r_sclk_s2 & r_sclk_d;
  assign w_last_bit  = (r_bit_cnt == LAST_BIT);
  assign w_byte_done = w_sclk_rise & w_last_bit;
  assign w_rx_byte   = {r_rx_shift[DATA_W-2:0], r_mosi_s2};

  assign w_tx_load = w_ssn_fall | w_byte_done;
  assign w_tx_push = tx_valid & ~r_tx_full;
  assign w_tx_next = r_tx_full ? r_tx_hold : {DATA_W{1'b1}};
  assign w_udr_set = w_tx_load & ~r_tx_full;

  // Shift engine: r_tx_fresh stops the falling edge after a mid-frame reload from skipping the new MSB
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_bit_cnt  <= '0;
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_tx_fresh <= 1'b0;
    end else if (!w_active) begin
      r_bit_cnt  <= '0;
      r_tx_fresh <= 1'b0;
    end else if (w_ssn_fall) begin
      r_bit_cnt  <= '0;
      r_tx_shift <= w_tx_next;
      r_tx_fresh <= 1'b0;
    end else if (w_sclk_rise) begin
      r_rx_shift <= w_rx_byte;
      if (w_last_bit) begin
        r_bit_cnt  <= '0;
        r_tx_shift <= w_tx_next;
        r_tx_fresh <= 1'b1;
      end else begin
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
    end else if (w_sclk_fall) begin
      if (r_tx_fresh)
        r_tx_fresh <= 1'b0;
      else
        r_tx_shift <= {r_tx_shift[DATA_W-2:0], 1'b0};
    end
  end

  // TX holding register: a push can only land while empty, a load only drains while full
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_tx_hold <= '0;
      r_tx_full <= 1'b0;
    end else if (w_tx_push) begin
      r_tx_hold <= tx_data;
      r_tx_full <= 1'b1;
    end else if (w_tx_load && r_tx_full) begin
      r_tx_full <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int DEPTH = 4;

  logic [DATA_W-1:0] r_fifo [DEPTH];
  logic [1:0]        r_wr_ptr, r_rd_ptr;
  logic [2:0]        r_count;

  assign w_rx_pop  = (r_count != 3'd0) & rx_ready;
  assign w_rx_room = (r_count != 3'(DEPTH)) | w_rx_pop;
  assign w_rx_wr   = w_byte_done & w_rx_room;
  assign w_ovr_set = w_byte_done & ~w_rx_room;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < DEPTH; i++)
        r_fifo[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_rx_wr) begin
        r_fifo[r_wr_ptr] <= w_rx_byte;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_rx_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + 3'(w_rx_wr) - 3'(w_rx_pop);
    end
  end

  assign rx_data  = r_fifo[r_rd_ptr];
  assign rx_valid = (r_count != 3'd0);
`else
  logic [DATA_W-1:0] r_rx_data;
  logic              r_rx_valid;

  // Room is judged after any same-cycle pop, so a pop and a completing byte never overrun
  assign w_rx_pop  = r_rx_valid & rx_ready;
  assign w_rx_room = ~r_rx_valid | w_rx_pop;
  assign w_rx_wr   = w_byte_done & w_rx_room;
  assign w_ovr_set = w_byte_done & ~w_rx_room;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else if (w_rx_wr) begin
      r_rx_data  <= w_rx_byte;
      r_rx_valid <= 1'b1;
    end else if (w_rx_pop) begin
      r_rx_valid <= 1'b0;
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
`endif

  // Sticky flags; a new event outranks a coincident clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ovr <= 1'b0;
      r_udr <= 1'b0;
    end else begin
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (clr)
        r_ovr <= 1'b0;
      if (w_udr_set)
        r_udr <= 1'b1;
      else if (clr)
        r_udr <= 1'b0;
    end
  end

  assign MISO     = r_tx_shift[DATA_W-1];
  assign MISO_oeb = ~w_active;
  assign tx_ready = ~r_tx_full;
  assign busy     = ~r_ssn_s2;
  assign ovr      = r_ovr;
  assign udr      = r_udr;

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: a mode-0 SPI master model driven from HCLK falling edges.
module tb_spi_slave_port;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       HCLK, HRESETn, SCLK, SSn, MOSI, MISO, MISO_oeb;
  logic [7:0] tx_data, rx_data;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic       busy, ovr, udr, clr;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] mi;
  logic [7:0] exp_b;

  spi_slave_port dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .SCLK     (SCLK),
    .SSn      (SSn),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .MISO_oeb (MISO_oeb),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .busy     (busy),
    .ovr      (ovr),
    .udr      (udr),
    .clr      (clr)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // SCLK half period is 8 HCLK cycles; MISO is sampled as SCLK rises
  task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit pop_last,
                          output logic [7:0] mo_in);
    mo_in = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[7-i];
      repeat (8) @(negedge HCLK);
      mo_in = {mo_in[6:0], MISO};
      SCLK  = 1'b1;
      if (pop_last && i == nbits - 1) begin
        repeat (2) @(negedge HCLK);
        rx_ready = 1'b1;
        @(negedge HCLK);
        rx_ready = 1'b0;
        repeat (5) @(negedge HCLK);
      end else begin
        repeat (8) @(negedge HCLK);
      end
      SCLK = 1'b0;
    end
  endtask

  task automatic begin_frame();
    @(negedge HCLK);
    SSn = 1'b0;
    repeat (8) @(negedge HCLK);
  endtask

  task automatic end_frame();
    repeat (8) @(negedge HCLK);
    SSn = 1'b1;
    repeat (6) @(negedge HCLK);
  endtask

  task automatic pop_rx();
    @(negedge HCLK);
    rx_ready = 1'b1;
    @(negedge HCLK);
    rx_ready = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] b);
    @(negedge HCLK);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge HCLK);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge HCLK);
    clr = 1'b1;
    @(negedge HCLK);
    clr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_miso"},     MISO,     0);
    check_eq({pfx, "_miso_oeb"}, MISO_oeb, 1);
    check_eq({pfx, "_tx_ready"}, tx_ready, 1);
    check_eq({pfx, "_rx_valid"}, rx_valid, 0);
    check_eq({pfx, "_rx_data"},  rx_data,  0);
    check_eq({pfx, "_busy"},     busy,     0);
    check_eq({pfx, "_ovr"},      ovr,      0);
    check_eq({pfx, "_udr"},      udr,      0);
  endtask

  initial begin
    HRESETn  = 1'b0;
    SCLK     = 1'b0;
    SSn      = 1'b1;
    MOSI     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    clr      = 1'b0;
    repeat (3) @(negedge HCLK);
    check_reset_outputs("rst");
    HRESETn = 1'b1;
    repeat (5) @(negedge HCLK);

    // Preloaded A5 goes out while 3C comes in; a second byte keeps the end-of-byte reload fed
    push_tx(8'hA5);
    check_eq("a5_tx_ready_full", tx_ready, 0);
    begin_frame();
    check_eq("a5_busy",     busy,     1);
    check_eq("a5_miso_oeb", MISO_oeb, 0);
    check_eq("a5_tx_ready_after_load", tx_ready, 1);
    push_tx(8'h5A);
    spi_bits(8'h3C, 8, 1'b0, mi);
    end_frame();
    check_eq("a5_miso_byte", mi,       8'hA5);
    check_eq("a5_rx_valid",  rx_valid, 1);
    check_eq("a5_rx_data",   rx_data,  8'h3C);
    check_eq("a5_ovr",       ovr,      0);
    check_eq("a5_udr",       udr,      0);
    check_eq("a5_oeb_idle",  MISO_oeb, 1);
    pop_rx();
    check_eq("a5_rx_popped", rx_valid, 0);

    // No preload: FF goes out and udr is flagged until cleared
    begin_frame();
    spi_bits(8'h00, 8, 1'b0, mi);
    end_frame();
    check_eq("udr_miso_byte", mi,       8'hFF);
    check_eq("udr_flag",      udr,      1);
    check_eq("udr_rx_data",   rx_data,  8'h00);
    check_eq("udr_rx_valid",  rx_valid, 1);
    pop_rx();
    pulse_clr();
    check_eq("udr_cleared", udr, 0);

    // Overrun with the consumer stalled; stored bytes stay in order
    begin_frame();
    for (int k = 0; k <= DEPTH; k++) begin
      exp_b = 8'(8'h11 * (k + 1));
      spi_bits(exp_b, 8, 1'b0, mi);
    end
    end_frame();
    check_eq("ovr_flag", ovr, 1);
    for (int k = 0; k < DEPTH; k++) begin
      exp_b = 8'(8'h11 * (k + 1));
      check_eq("ovr_rx_valid", rx_valid, 1);
      check_eq("ovr_rx_order", rx_data,  exp_b);
      pop_rx();
    end
    check_eq("ovr_drained", rx_valid, 0);
    pulse_clr();
    check_eq("ovr_cleared", ovr, 0);
    check_eq("ovr_udr_cleared", udr, 0);

    // Select released after 5 bits: partial byte is dropped
    begin_frame();
    spi_bits(8'hFF, 5, 1'b0, mi);
    end_frame();
    check_eq("abort_rx_valid", rx_valid, 0);
    check_eq("abort_miso_oeb", MISO_oeb, 1);
    check_eq("abort_busy",     busy,     0);
    begin_frame();
    spi_bits(8'h81, 8, 1'b0, mi);
    end_frame();
    check_eq("abort_next_valid", rx_valid, 1);
    check_eq("abort_next_data",  rx_data,  8'h81);
    pop_rx();

    // Reset in the middle of a byte, then clock a few bits while select is still held low
    push_tx(8'h3C);
    begin_frame();
    spi_bits(8'hA5, 4, 1'b0, mi);
    @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);
    check_reset_outputs("midrst");
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    spi_bits(8'hE0, 3, 1'b0, mi);
    end_frame();
    check_eq("midrst_stale_ignored", rx_valid, 0);
    begin_frame();
    spi_bits(8'h55, 8, 1'b0, mi);
    end_frame();
    check_eq("midrst_next_valid", rx_valid, 1);
    check_eq("midrst_next_data",  rx_data,  8'h55);
    pop_rx();
    pulse_clr();

    // Pop lands on the very cycle the next byte completes into full storage
    begin_frame();
    for (int k = 0; k < DEPTH; k++) begin
      exp_b = 8'(8'hC1 + k);
      spi_bits(exp_b, 8, 1'b0, mi);
    end
    spi_bits(8'h7E, 8, 1'b1, mi);
    end_frame();
    check_eq("popdone_ovr", ovr, 0);
    for (int k = 1; k < DEPTH; k++) begin
      exp_b = 8'(8'hC1 + k);
      check_eq("popdone_order", rx_data, exp_b);
      pop_rx();
    end
    check_eq("popdone_valid", rx_valid, 1);
    check_eq("popdone_new",   rx_data,  8'h7E);
    pop_rx();
    check_eq("popdone_empty", rx_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
